// File: rtl/register_bank.sv
// register_bank: 31-entry MIPS register storage with one write port, sequential clear engine, and write-first bypass when REGFILE_WRITE_BYPASS_EN is defined
module register_bank #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] SP_RESET_VAL = 32'h7FFF_EFFC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Reg_Write,
  input  logic [4:0]       Write_Register,
  input  logic [WIDTH-1:0] Write_Data,
  input  logic             Clear_Req,
  output logic             Clear_Busy,
  output logic [WIDTH-1:0] Q0,
  output logic [WIDTH-1:0] Q1,
  output logic [WIDTH-1:0] Q2,
  output logic [WIDTH-1:0] Q3,
  output logic [WIDTH-1:0] Q4,
  output logic [WIDTH-1:0] Q5,
  output logic [WIDTH-1:0] Q6,
  output logic [WIDTH-1:0] Q7,
  output logic [WIDTH-1:0] Q8,
  output logic [WIDTH-1:0] Q9,
  output logic [WIDTH-1:0] Q10,
  output logic [WIDTH-1:0] Q11,
  output logic [WIDTH-1:0] Q12,
  output logic [WIDTH-1:0] Q13,
  output logic [WIDTH-1:0] Q14,
  output logic [WIDTH-1:0] Q15,
  output logic [WIDTH-1:0] Q16,
  output logic [WIDTH-1:0] Q17,
  output logic [WIDTH-1:0] Q18,
  output logic [WIDTH-1:0] Q19,
  output logic [WIDTH-1:0] Q20,
  output logic [WIDTH-1:0] Q21,
  output logic [WIDTH-1:0] Q22,
  output logic [WIDTH-1:0] Q23,
  output logic [WIDTH-1:0] Q24,
  output logic [WIDTH-1:0] Q25,
  output logic [WIDTH-1:0] Q26,
  output logic [WIDTH-1:0] Q27,
  output logic [WIDTH-1:0] Q28,
  output logic [WIDTH-1:0] Q29,
  output logic [WIDTH-1:0] Q30,
  output logic [WIDTH-1:0] Q31
);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic we;
  logic [WIDTH-1:0] q [32];
  assign Clear_Busy = state_q == CLEAR;
  assign we = Reg_Write && !Clear_Busy;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= 5'd1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      state_d = Clear_Req ? CLEAR : IDLE;
      cnt_d = 5'd1;
    end else begin
      state_d = cnt_q == 5'd31 ? IDLE : CLEAR;
      cnt_d = cnt_q == 5'd31 ? 5'd1 : cnt_q + 5'd1;
    end
  end
  assign q[0] = '0;
  for (genvar i = 1; i < 32; i++) begin : g_reg
    localparam logic [WIDTH-1:0] RV = (i == 29) ? SP_RESET_VAL : '0;
    logic [WIDTH-1:0] rq;
    logic hit;
    assign hit = we && Write_Register == 5'(i);
    always_ff @(posedge clk or negedge reset)
      if (!reset) rq <= RV;
      else if (Clear_Busy && cnt_q == 5'(i)) rq <= RV;
      else if (hit) rq <= Write_Data;
`ifdef REGFILE_WRITE_BYPASS_EN
    assign q[i] = hit ? Write_Data : rq;
`else
    assign q[i] = rq;
`endif
  end
  assign Q0 = q[0];
  assign Q1 = q[1];
  assign Q2 = q[2];
  assign Q3 = q[3];
  assign Q4 = q[4];
  assign Q5 = q[5];
  assign Q6 = q[6];
  assign Q7 = q[7];
  assign Q8 = q[8];
  assign Q9 = q[9];
  assign Q10 = q[10];
  assign Q11 = q[11];
  assign Q12 = q[12];
  assign Q13 = q[13];
  assign Q14 = q[14];
  assign Q15 = q[15];
  assign Q16 = q[16];
  assign Q17 = q[17];
  assign Q18 = q[18];
  assign Q19 = q[19];
  assign Q20 = q[20];
  assign Q21 = q[21];
  assign Q22 = q[22];
  assign Q23 = q[23];
  assign Q24 = q[24];
  assign Q25 = q[25];
  assign Q26 = q[26];
  assign Q27 = q[27];
  assign Q28 = q[28];
  assign Q29 = q[29];
  assign Q30 = q[30];
  assign Q31 = q[31];
endmodule

// File: tb/tb_register_bank.sv
// tb_register_bank: randomized and directed checks of register_bank against a timeline-based reference model
module tb_register_bank;
  localparam logic [31:0] SP = 32'h7FFF_EFFC;
  logic clk = 0;
  logic reset = 0;
  logic Reg_Write = 0;
  logic [4:0] Write_Register = 0;
  logic [31:0] Write_Data = 0;
  logic Clear_Req = 0;
  logic Clear_Busy;
  logic [31:0] qv [32];
  logic [31:0] m [32];
  int ecount = 0;
  int cstart = -1;
  int busy_seen = 0;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  register_bank dut (
    .clk(clk), .reset(reset), .Reg_Write(Reg_Write), .Write_Register(Write_Register),
    .Write_Data(Write_Data), .Clear_Req(Clear_Req), .Clear_Busy(Clear_Busy),
    .Q0(qv[0]), .Q1(qv[1]), .Q2(qv[2]), .Q3(qv[3]), .Q4(qv[4]), .Q5(qv[5]), .Q6(qv[6]), .Q7(qv[7]),
    .Q8(qv[8]), .Q9(qv[9]), .Q10(qv[10]), .Q11(qv[11]), .Q12(qv[12]), .Q13(qv[13]), .Q14(qv[14]), .Q15(qv[15]),
    .Q16(qv[16]), .Q17(qv[17]), .Q18(qv[18]), .Q19(qv[19]), .Q20(qv[20]), .Q21(qv[21]), .Q22(qv[22]), .Q23(qv[23]),
    .Q24(qv[24]), .Q25(qv[25]), .Q26(qv[26]), .Q27(qv[27]), .Q28(qv[28]), .Q29(qv[29]), .Q30(qv[30]), .Q31(qv[31])
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] rv(input int n);
    return n == 29 ? SP : 32'h0;
  endfunction
  function automatic logic model_busy();
    return cstart >= 0;
  endfunction
  task automatic model_reset();
    for (int n = 0; n < 32; n++) m[n] = rv(n);
    cstart = -1;
  endtask
  // Register n is cleared at the n-th edge after the edge that accepted the request.
  task automatic model_edge();
    ecount++;
    if (model_busy()) begin
      m[ecount - cstart] = rv(ecount - cstart);
      if (ecount - cstart == 31) cstart = -1;
    end else begin
      if (Reg_Write && Write_Register != 0) m[Write_Register] = Write_Data;
      if (Clear_Req) cstart = ecount;
    end
  endtask
  task automatic compare_all(input string ph);
    logic [31:0] e;
    for (int n = 0; n < 32; n++) begin
      e = m[n];
`ifdef REGFILE_WRITE_BYPASS_EN
      if (reset && Reg_Write && !model_busy() && n != 0 && Write_Register == 5'(n)) e = Write_Data;
`endif
      check($sformatf("%s_Q%0d", ph, n), qv[n], e);
    end
    check({ph, "_busy"}, {31'b0, Clear_Busy}, {31'b0, model_busy()});
  endtask
  task automatic cycle(input logic we, input logic [4:0] wr, input logic [31:0] wd, input logic cr);
    Reg_Write = we;
    Write_Register = wr;
    Write_Data = wd;
    Clear_Req = cr;
    #1;
    compare_all("pre");
    @(posedge clk);
    model_edge();
    #1;
    compare_all("post");
    if (Clear_Busy) busy_seen++;
    @(negedge clk);
  endtask
  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    compare_all("rst_held");
    reset = 1;
    cycle(0, 0, 0, 0);
    cycle(1, 5, 32'hDEAD_BEEF, 0);
    cycle(1, 0, 32'h1234, 0);
    check("q5_written", qv[5], 32'hDEAD_BEEF);
    check("q0_zero", qv[0], 32'h0);
    for (int n = 1; n < 32; n++) cycle(1, 5'(n), 32'(n), 0);
    busy_seen = 0;
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 34; i++) begin
      if (i == 5) cycle(1, 31, 32'hFFFF_FFFF, 1);
      else if (i == 20) cycle(0, 0, 0, 1);
      else cycle(0, 0, 0, 0);
    end
    check("busy_cycles", 32'(busy_seen), 32'd31);
    check("q31_after_clear", qv[31], 32'h0);
    check("q29_after_clear", qv[29], SP);
    for (int n = 1; n < 32; n++) cycle(1, 5'(n), 32'(n * 3), 0);
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0);
    reset = 0;
    #1;
    model_reset();
    compare_all("rst_mid");
    check("busy_rst_mid", {31'b0, Clear_Busy}, 32'h0);
    @(negedge clk);
    reset = 1;
    busy_seen = 0;
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 33; i++) cycle(0, 0, 0, 0);
    check("busy_cycles_after_rst", 32'(busy_seen), 32'd31);
    cycle(1, 7, 32'h0000_0011, 0);
    Reg_Write = 1;
    Write_Register = 7;
    Write_Data = 32'hA5A5_A5A5;
    #1;
`ifdef REGFILE_WRITE_BYPASS_EN
    check("q7_same_cycle", qv[7], 32'hA5A5_A5A5);
`else
    check("q7_same_cycle", qv[7], 32'h0000_0011);
`endif
    @(posedge clk);
    model_edge();
    #1;
    check("q7_after_edge", qv[7], 32'hA5A5_A5A5);
    @(negedge clk);
    for (int i = 0; i < 1500; i++)
      cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom, $urandom_range(0, 39) == 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
